// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, branch flushes and
// memory-wait freezing with timeout, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1_addr,
    input  logic [3:0]       src2_addr,
    input  logic             two_src,
    input  logic [3:0]       exe_dest,
    input  logic [3:0]       mem_dest,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic             exe_mem_read,
    input  logic             forward_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_cnt,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             idex_freeze,
    output logic             exmem_freeze,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_mem_timeout;

    logic w_exe_hit1;
    logic w_exe_hit2;
    logic w_mem_hit1;
    logic w_mem_hit2;
    logic w_haz;
    logic w_mstall;
    logic w_branch_flush;
    logic w_pc_freeze;
    logic w_ifid_freeze;
    logic w_idex_freeze;
    logic w_exmem_freeze;
    logic w_ifid_flush;
    logic w_idex_flush;

    // Register 0 is compared like any other register.
    always_comb begin
        w_exe_hit1 = exe_wb_en & (exe_dest == src1_addr);
        w_exe_hit2 = exe_wb_en & two_src & (exe_dest == src2_addr);
        w_mem_hit1 = mem_wb_en & (mem_dest == src1_addr);
        w_mem_hit2 = mem_wb_en & two_src & (mem_dest == src2_addr);
        if (forward_en) begin
            w_haz = exe_mem_read & (w_exe_hit1 | w_exe_hit2);
        end else begin
            w_haz = w_exe_hit1 | w_exe_hit2 | w_mem_hit1 | w_mem_hit2;
        end
        w_mstall = mem_req & ~mem_ready;
    end

    always_comb begin
        w_pc_freeze    = 1'b0;
        w_ifid_freeze  = 1'b0;
        w_idex_freeze  = 1'b0;
        w_exmem_freeze = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_branch_flush = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (w_mstall) begin
                    w_pc_freeze    = 1'b1;
                    w_ifid_freeze  = 1'b1;
                    w_idex_freeze  = 1'b1;
                    w_exmem_freeze = 1'b1;
                end else if (branch_taken) begin
                    w_ifid_flush   = 1'b1;
                    w_idex_flush   = 1'b1;
                    w_branch_flush = 1'b1;
                end else if (w_haz) begin
                    w_pc_freeze    = 1'b1;
                    w_ifid_freeze  = 1'b1;
                    w_idex_flush   = 1'b1;
                end
            end
            ST_MEM_WAIT, ST_ERR: begin
                w_pc_freeze    = 1'b1;
                w_ifid_freeze  = 1'b1;
                w_idex_freeze  = 1'b1;
                w_exmem_freeze = 1'b1;
            end
            default: begin
                w_pc_freeze    = 1'b0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of inputs.
    assign pc_freeze    = rst & w_pc_freeze;
    assign ifid_freeze  = rst & w_ifid_freeze;
    assign idex_freeze  = rst & w_idex_freeze;
    assign exmem_freeze = rst & w_exmem_freeze;
    assign ifid_flush   = rst & w_ifid_flush;
    assign idex_flush   = rst & w_idex_flush;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_mstall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == LP_MAX_WAIT) begin
                        r_state       <= ST_ERR;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_ERR: begin
                    r_state       <= ST_ERR;
                    r_mem_timeout <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_freeze && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_branch_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule
